// File: rtl/encoder_10to4_pkg.sv
// encoder_10to4_pkg: shared constants and width helper for the one-hot line encoder.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   N_IN_DEF   default number of input lines
//   idx_width  ceiling log2 of a line count (minimum 1 bit)
//   W_OUT_DEF  default output index width, derived from N_IN_DEF
package encoder_10to4_pkg;

  localparam int N_IN_DEF = 10;

  // Smallest width w such that 2**w >= n; a single line still needs one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int W_OUT_DEF = idx_width(N_IN_DEF);

endpackage : encoder_10to4_pkg

// File: rtl/encoder_core_comb.sv
// encoder_core_comb: combinational one-hot to binary index encoder with presence/multi-hot flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input continuously.
//
// Ports:
//   in_i     [N_IN-1:0]   input line vector, bit k means index k
//   idx_o    [W_OUT-1:0]  index of the winning set bit (0 when none set)
//   any_o                 at least one bit set
//   multi_o               two or more bits set
module encoder_core_comb
  import encoder_10to4_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int W_OUT    = W_OUT_DEF,
  parameter int PRI_HIGH = 1
) (
  input  logic [N_IN-1:0]  in_i,
  output logic [W_OUT-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  logic seen;
  logic multi;

  always_comb begin
    idx_o = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      // The last match in scan order wins: an ascending scan leaves the
      // highest set bit, a descending scan leaves the lowest.
      if (PRI_HIGH != 0) begin
        if (in_i[k]) begin
          idx_o = W_OUT'(k);
        end
      end else begin
        if (in_i[N_IN-1-k]) begin
          idx_o = W_OUT'(N_IN - 1 - k);
        end
      end
      // A set bit seen after an earlier set bit means multi-hot.
      multi = multi | (seen & in_i[k]);
      seen  = seen | in_i[k];
    end
  end

  assign any_o   = seen;
  assign multi_o = multi;

endmodule : encoder_core_comb

// File: rtl/encoder_10to4.sv
// encoder_10to4: registered one-hot line encoder with valid and multi-hot error qualifiers.
// Latency: 1 cycle from an iEN=1 rising edge to oOUT/oVALID/oERR; no combinational input-to-output path.
// Backpressure: none; iEN=0 simply holds all output registers.
//
// Ports:
//   iCLK    clock, rising edge
//   iRSTn   asynchronous active-low reset, clears all outputs
//   iEN     capture enable
//   iIN     [N_IN-1:0] input line vector
//   oOUT    [W_OUT-1:0] encoded index (0 when idle)
//   oVALID  captured input had at least one bit set
//   oERR    captured input had two or more bits set
module encoder_10to4
  import encoder_10to4_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int W_OUT    = W_OUT_DEF,
  parameter int PRI_HIGH = 1
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iEN,
  input  logic [N_IN-1:0]  iIN,
  output logic [W_OUT-1:0] oOUT,
  output logic             oVALID,
  output logic             oERR
);

  logic [W_OUT-1:0] idx_c;
  logic             any_c;
  logic             multi_c;

  logic [W_OUT-1:0] out_d,   out_q;
  logic             valid_d, valid_q;
  logic             err_d,   err_q;

  encoder_core_comb #(
    .N_IN     (N_IN),
    .W_OUT    (W_OUT),
    .PRI_HIGH (PRI_HIGH)
  ) u_core (
    .in_i    (iIN),
    .idx_o   (idx_c),
    .any_o   (any_c),
    .multi_o (multi_c)
  );

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (iEN) begin
      out_d   = idx_c;
      valid_d = any_c;
      err_d   = multi_c;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign oOUT   = out_q;
  assign oVALID = valid_q;
  assign oERR   = err_q;

endmodule : encoder_10to4

// File: tb/tb_encoder_10to4.sv
// tb_encoder_10to4: directed scoreboard bench for encoder_10to4 (high- and low-priority instances).
// Latency: expects outputs one rising edge after each driven vector.
// Backpressure: n/a.
module tb_encoder_10to4;

  logic       iCLK = 1'b0;
  logic       iRSTn;
  logic       iEN;
  logic [9:0] iIN;

  logic [3:0] out_hi, out_lo;
  logic       vld_hi, vld_lo;
  logic       err_hi, err_lo;

  always #5 iCLK = ~iCLK;

  encoder_10to4 #(.N_IN(10), .W_OUT(4), .PRI_HIGH(1)) u_dut_hi (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iEN    (iEN),
    .iIN    (iIN),
    .oOUT   (out_hi),
    .oVALID (vld_hi),
    .oERR   (err_hi)
  );

  encoder_10to4 #(.N_IN(10), .W_OUT(4), .PRI_HIGH(0)) u_dut_lo (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iEN    (iEN),
    .iIN    (iIN),
    .oOUT   (out_lo),
    .oVALID (vld_lo),
    .oERR   (err_lo)
  );

  typedef struct {
    int         due;
    logic [3:0] out_hi;
    logic [3:0] out_lo;
    logic       vld;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Drive one vector between edges; its effect is due after the next rising edge.
  task automatic drive(input logic en, input logic [9:0] in, input logic [3:0] e_hi,
                       input logic [3:0] e_lo, input logic e_vld, input logic e_err,
                       input string name);
    exp_t e;
    @(negedge iCLK);
    iEN = en;
    iIN = in;
    e.due    = cyc + 1;
    e.out_hi = e_hi;
    e.out_lo = e_lo;
    e.vld    = e_vld;
    e.err    = e_err;
    e.name   = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation whose capture edge has passed.
  always @(negedge iCLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".out_hi"}, 32'(out_hi), 32'(e.out_hi));
      check({e.name, ".out_lo"}, 32'(out_lo), 32'(e.out_lo));
      check({e.name, ".vld_hi"}, 32'(vld_hi), 32'(e.vld));
      check({e.name, ".vld_lo"}, 32'(vld_lo), 32'(e.vld));
      check({e.name, ".err_hi"}, 32'(err_hi), 32'(e.err));
      check({e.name, ".err_lo"}, 32'(err_lo), 32'(e.err));
    end
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(negedge iCLK);
      #1;
      t++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: %0d expectations pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    check({name, ".out_hi"}, 32'(out_hi), 32'd0);
    check({name, ".out_lo"}, 32'(out_lo), 32'd0);
    check({name, ".vld_hi"}, 32'(vld_hi), 32'd0);
    check({name, ".err_hi"}, 32'(err_hi), 32'd0);
  endtask

  initial begin
    // Reset held across edges while enable and all-ones input are applied.
    iRSTn = 1'b0;
    iEN   = 1'b1;
    iIN   = 10'b11_1111_1111;
    repeat (2) @(negedge iCLK);
    check_zero("reset");
    iEN   = 1'b0;
    iIN   = 10'b0;
    iRSTn = 1'b1;

    // Walking one: index equals bit position, no error.
    drive(1'b1, 10'b00_0000_0001, 4'd0, 4'd0, 1'b1, 1'b0, "walk0");
    drive(1'b1, 10'b00_0000_0010, 4'd1, 4'd1, 1'b1, 1'b0, "walk1");
    drive(1'b1, 10'b00_0000_0100, 4'd2, 4'd2, 1'b1, 1'b0, "walk2");
    drive(1'b1, 10'b00_0000_1000, 4'd3, 4'd3, 1'b1, 1'b0, "walk3");
    drive(1'b1, 10'b00_0001_0000, 4'd4, 4'd4, 1'b1, 1'b0, "walk4");
    drive(1'b1, 10'b00_0010_0000, 4'd5, 4'd5, 1'b1, 1'b0, "walk5");
    drive(1'b1, 10'b00_0100_0000, 4'd6, 4'd6, 1'b1, 1'b0, "walk6");
    drive(1'b1, 10'b00_1000_0000, 4'd7, 4'd7, 1'b1, 1'b0, "walk7");
    drive(1'b1, 10'b01_0000_0000, 4'd8, 4'd8, 1'b1, 1'b0, "walk8");
    drive(1'b1, 10'b10_0000_0000, 4'd9, 4'd9, 1'b1, 1'b0, "walk9");

    // Idle and multi-hot patterns.
    drive(1'b1, 10'b00_0000_0000, 4'd0, 4'd0, 1'b0, 1'b0, "idle");
    drive(1'b1, 10'b10_0000_0001, 4'd9, 4'd0, 1'b1, 1'b1, "multi_9_0");
    drive(1'b1, 10'b00_0001_1000, 4'd4, 4'd3, 1'b1, 1'b1, "multi_4_3");
    drive(1'b1, 10'b11_1111_1111, 4'd9, 4'd0, 1'b1, 1'b1, "all_ones");
    drive(1'b1, 10'b00_0100_0100, 4'd6, 4'd2, 1'b1, 1'b1, "multi_6_2");

    // Hold: capture 5, then iEN low with a different input for 3 cycles.
    drive(1'b1, 10'b00_0010_0000, 4'd5, 4'd5, 1'b1, 1'b0, "hold_cap");
    drive(1'b0, 10'b00_0000_1000, 4'd5, 4'd5, 1'b1, 1'b0, "hold1");
    drive(1'b0, 10'b00_0000_1000, 4'd5, 4'd5, 1'b1, 1'b0, "hold2");
    drive(1'b0, 10'b00_0000_1000, 4'd5, 4'd5, 1'b1, 1'b0, "hold3");
    drive(1'b0, 10'b00_0000_0000, 4'd5, 4'd5, 1'b1, 1'b0, "hold_idle");

    // Leave the outputs at 7 for the asynchronous reset check.
    drive(1'b1, 10'b00_1000_0000, 4'd7, 4'd7, 1'b1, 1'b0, "pre_rst");
    drive(1'b0, 10'b00_1000_0000, 4'd7, 4'd7, 1'b1, 1'b0, "pre_rst_hold");
    drain("drain_pre_rst");

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2;
    check("pre_rst.out_hi_is_7", 32'(out_hi), 32'd7);
    iRSTn = 1'b0;
    #1;
    check_zero("async_rst");
    iEN = 1'b1;
    iIN = 10'b00_0000_0100;
    @(negedge iCLK);
    check_zero("rst_overrides_en");
    iRSTn = 1'b1;
    @(posedge iCLK);
    #1;
    check("post_rst.out_hi", 32'(out_hi), 32'd2);
    check("post_rst.out_lo", 32'(out_lo), 32'd2);
    check("post_rst.vld_hi", 32'(vld_hi), 32'd1);
    check("post_rst.err_hi", 32'(err_hi), 32'd0);

    drive(1'b1, 10'b01_0000_0000, 4'd8, 4'd8, 1'b1, 1'b0, "post_rst8");
    drive(1'b1, 10'b00_0000_0011, 4'd1, 4'd0, 1'b1, 1'b1, "multi_1_0");
    drive(1'b1, 10'b00_0000_0000, 4'd0, 4'd0, 1'b0, 1'b0, "idle_end");
    drain("drain_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_encoder_10to4
